rr_shift_reg_param: RTL and testbench
=====================================

Name: rr_shift_reg_param

Overview:
- Parametrised multi-word operand register for the modular-division datapath.
- Holds an N-word big integer V and supports:
  - word-serial load, with the least-significant word exposed as the unload port;
  - 1-bit right and left shifts with serial fill;
  - clear, and set-to-one (operand initialisation);
  - a sequenced multi-bit right shift driven by a start/busy/done handshake.
- Provides LSB and zero-detect flags for the inversion/GCD control FSM.

Parameters:
WORD_W, 32, bits per word
NUM_WORDS, 8, number of words; total width TOT_W = WORD_W*NUM_WORDS
SHAMT_W, 9, width of shamt; must satisfy 2^SHAMT_W > TOT_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  command strobe; accepted only when busy=0
op  input  3  command: 0 NOP, 1 LOAD_WORD, 2 SHR1, 3 SHL1, 4 CLR, 5 SET1, 6 SHRN, 7 reserved (treated as NOP)
din  input  WORD_W  word loaded by LOAD_WORD
sin  input  1  serial fill bit for SHR1/SHL1/SHRN
shamt  input  SHAMT_W  shift count for SHRN, sampled at accept
word_out  output  WORD_W  least-significant word V[WORD_W-1:0]
value  output  TOT_W  full register contents V
lsb  output  1  V[0]
is_zero  output  1  1 when V==0
busy  output  1  high while SHRN is in progress
done  output  1  one-cycle pulse after any accepted command completes

Behaviour:
- Word layout: word 0 is the most-significant word, V = {w0,...,w(N-1)}.
- Reset (async, any time, including mid-SHRN):
  - V=0; FSM returns to IDLE; busy=0; done=0.
  - Consequently word_out=0, lsb=0, is_zero=1.
- Accept: a command is accepted at a rising edge when start=1 and FSM=IDLE; start is ignored while busy=1.
- Single-cycle ops; V updates at the accepting edge:
  - LOAD_WORD: V <= {din, V[TOT_W-1:WORD_W]}. After N loads, the first word loaded sits in w(N-1). The previous word_out is discarded; the bench reads word_out before each LOAD_WORD to unload.
  - SHR1: V <= {sin, V[TOT_W-1:1]}.
  - SHL1: V <= {V[TOT_W-2:0], sin}; the MSB is lost.
  - CLR: V <= 0.
  - SET1: V <= 1, i.e. only bit 0 set.
  - NOP and reserved codes: V unchanged, done still pulses.
- done timing: high for exactly one cycle, the cycle following the edge that completes the command.
- SHRN FSM, two states:
  - IDLE: on accept with shamt=n >= 1, go to SHIFT and load cnt=n; busy rises the cycle after the accept edge. No shift occurs at the accept edge.
  - SHIFT: each edge performs V <= {sin, V>>1} and decrements cnt. The edge where cnt==1 is the last shift; go to IDLE and pulse done the following cycle.
  - Total: exactly n shifts, busy high for n cycles, done n+1 cycles after accept.
  - shamt=0: no shift, no busy; done pulses the next cycle, identical to NOP.
  - shamt > TOT_W: still shifts shamt times; the result is all-sin fill.
  - sin is sampled on every shift edge, so a caller may stream bits.
- Outputs: word_out, value, lsb and is_zero are combinational from V and always reflect current contents, including during SHIFT.
- The command path has no back-pressure other than busy. done and a new accept may coincide: done of command k is high in the same cycle that command k+1 is accepted.

Test Plan:
- Reset: assert rst mid-SHRN (shamt=20, after 5 shifts) -> V=0, busy=0, done=0, is_zero=1 immediately, without waiting for a clock edge.
- Load/unload: 8x LOAD_WORD with din=32'h0000_0001..32'h0000_0008 -> w7=1, w0=8, word_out=32'h1. 8 further LOAD_WORD of 0 -> word_out sequence 1,2,...,8 sampled before each edge, then is_zero=1.
- Single shifts: SET1 -> lsb=1, value=1. SHL1 with sin=0 x255 -> value[255]=1, lsb=0. SHR1 with sin=1 -> value = 2^255 + 2^254.
- SHRN: V=256'h1_0000_0000 (bit 32), shamt=32, sin=0 -> busy high for 32 cycles, done on cycle 33 after accept, V=1, lsb=1.
- Handshake edge cases:
  - start with SHL1 while busy -> ignored, V unchanged.
  - SHRN shamt=0 -> done next cycle, busy never high.
  - Back-to-back SHR1 on consecutive cycles -> each accepted, done high two consecutive cycles.
- CLR after SET1, and reserved op=7 -> V=0 after CLR; op=7 leaves V unchanged but pulses done.

Source files
------------

// File: rtl/rr_shift_reg_param_if.sv
// Command/status bundle for the multi-word operand register.
// The master issues commands; the slave (the register) reports contents and status.
interface rr_shift_reg_param_if #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int SHAMT_W   = 9
);
  localparam int TOT_W = WORD_W * NUM_WORDS;

  logic               start;
  logic [2:0]         op;
  logic [WORD_W-1:0]  din;
  logic               sin;
  logic [SHAMT_W-1:0] shamt;
  logic [WORD_W-1:0]  word_out;
  logic [TOT_W-1:0]   value;
  logic               lsb;
  logic               is_zero;
  logic               busy;
  logic               done;
  logic               dbg_shift;

  modport master (
    output start, op, din, sin, shamt,
    input  word_out, value, lsb, is_zero, busy, done, dbg_shift
  );

  modport slave (
    input  start, op, din, sin, shamt,
    output word_out, value, lsb, is_zero, busy, done, dbg_shift
  );
endinterface

// File: rtl/rr_shift_reg_param.sv
// N-word operand register with word-serial load, single-bit shifts,
// clear/set-to-one and a sequenced multi-bit right shift.
module rr_shift_reg_param #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int SHAMT_W   = 9
) (
  input logic                 clk,
  input logic                 rst,
  rr_shift_reg_param_if.slave bus
);
  localparam int TOT_W = WORD_W * NUM_WORDS;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHR1 = 3'd2;
  localparam logic [2:0] OP_SHL1 = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_SET1 = 3'd5;
  localparam logic [2:0] OP_SHRN = 3'd6;

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t             r_state;
  logic [TOT_W-1:0]   r_v;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_done;

  // Handshake: a command is taken on a rising edge when start=1 and the FSM is
  // idle (busy=0); start is ignored while busy. done pulses for one cycle after
  // the completing edge and may coincide with the accept of the next command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_v     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_done <= 1'b1;
            case (bus.op)
              OP_LOAD: r_v <= {bus.din, r_v[TOT_W-1:WORD_W]};
              OP_SHR1: r_v <= {bus.sin, r_v[TOT_W-1:1]};
              OP_SHL1: r_v <= {r_v[TOT_W-2:0], bus.sin};
              OP_CLR:  r_v <= '0;
              OP_SET1: r_v <= TOT_W'(1);
              OP_SHRN: begin
                // shamt=0 degenerates to a NOP with an immediate done
                if (bus.shamt != '0) begin
                  r_done  <= 1'b0;
                  r_state <= ST_SHIFT;
                  r_cnt   <= bus.shamt;
                end
              end
              default: ;
            endcase
          end
        end
        ST_SHIFT: begin
          r_v   <= {bus.sin, r_v[TOT_W-1:1]};
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.word_out  = r_v[WORD_W-1:0];
  assign bus.value     = r_v;
  assign bus.lsb       = r_v[0];
  assign bus.is_zero   = (r_v == '0);
  assign bus.busy      = (r_state == ST_SHIFT);
  assign bus.done      = r_done;
  assign bus.dbg_shift = (r_state == ST_SHIFT);

  logic w_unused_ok;
  assign w_unused_ok = (OP_NOP == 3'd0);
endmodule

// File: tb/tb_rr_shift_reg_param.sv
// Directed bench for rr_shift_reg_param: table of single-cycle commands plus
// hand-written sequences for load/unload, long shifts, SHRN and reset.
module tb_rr_shift_reg_param;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int SHAMT_W   = 9;
  localparam int TOT_W     = WORD_W * NUM_WORDS;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHR1 = 3'd2;
  localparam logic [2:0] OP_SHL1 = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_SET1 = 3'd5;
  localparam logic [2:0] OP_SHRN = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  logic clk;
  logic rst;

  rr_shift_reg_param_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .SHAMT_W(SHAMT_W)) bus ();

  rr_shift_reg_param #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .SHAMT_W(SHAMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [WORD_W-1:0] exp_q[$];

  task automatic chk_v(input string name, input logic [TOT_W-1:0] act, input logic [TOT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: present one command for exactly one rising edge, return #1 after it
  task automatic apply(input logic [2:0] op, input logic [WORD_W-1:0] din,
                       input logic sin, input logic [SHAMT_W-1:0] shamt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.din   = din;
    bus.sin   = sin;
    bus.shamt = shamt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic chk_all(input string name, input logic [TOT_W-1:0] exp);
    chk_v({name, ".value"}, bus.value, exp);
    chk_w({name, ".word_out"}, bus.word_out, exp[WORD_W-1:0]);
    chk_b({name, ".lsb"}, bus.lsb, exp[0]);
    chk_b({name, ".is_zero"}, bus.is_zero, exp == '0);
  endtask

  typedef struct {
    logic [2:0]         op;
    logic [WORD_W-1:0]  din;
    logic               sin;
    logic [SHAMT_W-1:0] shamt;
    logic [TOT_W-1:0]   exp_v;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [TOT_W-1:0] exp;
    int busy_cnt;
    int done_cnt;
    int done_k;

    vecs[0]  = '{OP_SET1, 32'h0, 1'b0, 9'd0, 256'h1};
    vecs[1]  = '{OP_SHL1, 32'h0, 1'b1, 9'd0, 256'h3};
    vecs[2]  = '{OP_SHL1, 32'h0, 1'b0, 9'd0, 256'h6};
    vecs[3]  = '{OP_SHR1, 32'h0, 1'b0, 9'd0, 256'h3};
    vecs[4]  = '{OP_SHR1, 32'h0, 1'b1, 9'd0, {1'b1, 254'd0, 1'b1}};
    vecs[5]  = '{OP_LOAD, 32'hDEAD_BEEF, 1'b0, 9'd0, {32'hDEAD_BEEF, 1'b1, 223'd0}};
    vecs[6]  = '{OP_RSV,  32'h1234_5678, 1'b1, 9'd0, {32'hDEAD_BEEF, 1'b1, 223'd0}};
    vecs[7]  = '{OP_NOP,  32'h1234_5678, 1'b1, 9'd0, {32'hDEAD_BEEF, 1'b1, 223'd0}};
    vecs[8]  = '{OP_CLR,  32'h0, 1'b0, 9'd0, 256'h0};
    vecs[9]  = '{OP_SET1, 32'h0, 1'b0, 9'd0, 256'h1};
    vecs[10] = '{OP_CLR,  32'h0, 1'b0, 9'd0, 256'h0};
    vecs[11] = '{OP_SHRN, 32'h0, 1'b1, 9'd0, 256'h0};
    vecs[12] = '{OP_SET1, 32'h0, 1'b0, 9'd0, 256'h1};
    vecs[13] = '{OP_SHRN, 32'h0, 1'b1, 9'd0, 256'h1};

    bus.start = 1'b0;
    bus.op    = OP_NOP;
    bus.din   = '0;
    bus.sin   = 1'b0;
    bus.shamt = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("reset", '0);
    chk_b("reset.busy", bus.busy, 1'b0);
    chk_b("reset.done", bus.done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // table-driven single-cycle commands, issued back to back
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].op, vecs[i].din, vecs[i].sin, vecs[i].shamt);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_v);
      chk_b($sformatf("vec%0d.done", i), bus.done, 1'b1);
      chk_b($sformatf("vec%0d.busy", i), bus.busy, 1'b0);
    end
    @(posedge clk);
    #1;
    chk_b("idle.done", bus.done, 1'b0);

    // word-serial load then unload
    apply(OP_CLR, '0, 1'b0, '0);
    for (int i = 1; i <= 8; i++) apply(OP_LOAD, WORD_W'(i), 1'b0, '0);
    exp = '0;
    for (int k = 0; k < 8; k++) exp[k*WORD_W +: WORD_W] = WORD_W'(k + 1);
    chk_all("load8", exp);
    for (int i = 1; i <= 8; i++) exp_q.push_back(WORD_W'(i));
    for (int i = 0; i < 8; i++) begin
      chk_w($sformatf("unload%0d", i), bus.word_out, exp_q.pop_front());
      apply(OP_LOAD, '0, 1'b0, '0);
    end
    chk_b("unload.is_zero", bus.is_zero, 1'b1);

    // single-bit shifts across the full width
    apply(OP_SET1, '0, 1'b0, '0);
    chk_b("set1.lsb", bus.lsb, 1'b1);
    repeat (255) apply(OP_SHL1, '0, 1'b0, '0);
    exp = '0;
    exp[255] = 1'b1;
    chk_all("shl255", exp);
    apply(OP_SHR1, '0, 1'b1, '0);
    exp[254] = 1'b1;
    chk_all("shr1_fill", exp);

    // back-to-back SHR1: done stays high on consecutive cycles
    apply(OP_SET1, '0, 1'b0, '0);
    apply(OP_SHR1, '0, 1'b0, '0);
    chk_b("b2b.done1", bus.done, 1'b1);
    chk_all("b2b.v1", '0);
    apply(OP_SHR1, '0, 1'b1, '0);
    chk_b("b2b.done2", bus.done, 1'b1);
    exp = '0;
    exp[255] = 1'b1;
    chk_all("b2b.v2", exp);
    @(posedge clk);
    #1;
    chk_b("b2b.done_drop", bus.done, 1'b0);

    // SHRN by 32 with an ignored SHL1 issued while busy
    apply(OP_SET1, '0, 1'b0, '0);
    repeat (32) apply(OP_SHL1, '0, 1'b0, '0);
    exp = '0;
    exp[32] = 1'b1;
    chk_all("bit32", exp);
    apply(OP_SHRN, '0, 1'b0, 9'd32);
    chk_b("shrn.no_shift_at_accept", bus.value[32], 1'b1);
    busy_cnt = 0;
    done_cnt = 0;
    done_k   = -1;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 6) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_SHL1;
        bus.sin   = 1'b0;
      end
    end
    chk_i("shrn.busy_cycles", busy_cnt, 32);
    chk_i("shrn.done_edge", done_k, 32);
    chk_i("shrn.done_pulses", done_cnt, 1);
    chk_all("shrn.result", 256'h1);
    chk_b("shrn.busy_end", bus.busy, 1'b0);

    // asynchronous reset in the middle of a SHRN
    apply(OP_LOAD, 32'hFFFF_FFFF, 1'b0, '0);
    apply(OP_SHRN, '0, 1'b1, 9'd20);
    repeat (5) @(posedge clk);
    #1;
    chk_b("rst_mid.busy_before", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_all("rst_mid", '0);
    chk_b("rst_mid.busy", bus.busy, 1'b0);
    chk_b("rst_mid.done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst_mid.after", '0);
    chk_b("rst_mid.after_busy", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
